// File: rtl/alrdwr_arb2_pkg.sv
// Shared types and helpers for the two-master AL read/write arbiter.
package alrdwr_arb2_pkg;

  localparam int unsigned AL_PORT_W = 1;
  localparam int unsigned RD_CNT_W  = 4;

  typedef enum logic [AL_PORT_W-1:0] {
    AL_PORT0 = 1'b0,
    AL_PORT1 = 1'b1
  } al_port_e;

  // Prepends the upstream port bit above an id_w-bit upstream read ID.
  function automatic logic [31:0] al_widen_id(al_port_e port, logic [31:0] id,
                                              int unsigned id_w);
    logic [31:0] mask;
    mask = (32'd1 << id_w) - 32'd1;
    return (32'(port) << id_w) | (id & mask);
  endfunction

endpackage

// File: rtl/alrdwr_arb2_if.sv
// AL single-beat read/write bus; master drives requests, slave drives responses.
interface alrdwr_arb2_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_BITS  = 2,
  parameter int unsigned ID_WIDTH   = 1
);
  localparam int unsigned DATA_WIDTH = 8 << DATA_BITS;

  logic [ADDR_WIDTH-1:DATA_BITS] waddr;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          wvalid;
  logic                          wready;
  logic [ADDR_WIDTH-1:DATA_BITS] araddr;
  logic [ID_WIDTH-1:0]           arid;
  logic                          arvalid;
  logic                          arready;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [ID_WIDTH-1:0]           rid;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output waddr, wdata, wvalid, araddr, arid, arvalid, rready,
    input  wready, arready, rdata, rid, rvalid
  );

  modport slave (
    input  waddr, wdata, wvalid, araddr, arid, arvalid, rready,
    output wready, arready, rdata, rid, rvalid
  );

endinterface

// File: rtl/alrdwr_rr_sel.sv
// Two-way round-robin grant with a lock that holds a stalled grant until its handshake.
module alrdwr_rr_sel
  import alrdwr_arb2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_gate,
  input  logic       i_ready,
  output al_port_e   o_sel,
  output logic       o_valid,
  output logic [1:0] o_grant_ready
);

  al_port_e r_last;
  al_port_e r_lock_sel;
  logic     r_lock;
  al_port_e w_sel;
  logic     w_valid;
  logic     w_ready;

  always_comb begin
    w_sel = AL_PORT0;
    if (r_lock)
      w_sel = r_lock_sel;
    else if (&i_req)
      w_sel = (r_last == AL_PORT1) ? AL_PORT0 : AL_PORT1;
    else if (i_req[1])
      w_sel = AL_PORT1;
  end

  assign w_valid = ((w_sel == AL_PORT1) ? i_req[1] : i_req[0]) & i_gate;
  assign w_ready = i_ready & i_gate;

  assign o_sel            = w_sel;
  assign o_valid          = w_valid;
  assign o_grant_ready[0] = (w_sel == AL_PORT0) & w_ready;
  assign o_grant_ready[1] = (w_sel == AL_PORT1) & w_ready;

  // A stalled transaction is pinned so a late request on the other port cannot swap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= AL_PORT1;
      r_lock     <= 1'b0;
      r_lock_sel <= AL_PORT0;
    end else if (w_valid && w_ready) begin
      r_last <= w_sel;
      r_lock <= 1'b0;
    end else if (w_valid) begin
      r_lock     <= 1'b1;
      r_lock_sel <= w_sel;
    end
  end

endmodule

// File: rtl/alrdwr_arb2.sv
// Shares one AL slave between two masters: independent round-robin W/AR, ID-routed R.
module alrdwr_arb2
  import alrdwr_arb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_BITS  = 2,
  parameter int unsigned DATA_WIDTH = 8 << DATA_BITS,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned MAX_RD     = 4
) (
  input  logic          clk,
  input  logic          rst,
  alrdwr_arb2_if.slave  s0_al,
  alrdwr_arb2_if.slave  s1_al,
  alrdwr_arb2_if.master m_al
);

  localparam int unsigned           MID_W    = ID_WIDTH + 1;
  localparam logic [RD_CNT_W-1:0]   MAX_RD_C = RD_CNT_W'(MAX_RD);

  al_port_e                      w_w_sel;
  al_port_e                      w_ar_sel;
  logic [1:0]                    w_wready;
  logic [1:0]                    w_arready;
  logic                          w_ar_gate;
  logic                          w_ar_hs;
  logic                          w_r_hs;
  logic                          w_rport;
  logic [ADDR_WIDTH-1:DATA_BITS] w_waddr;
  logic [ADDR_WIDTH-1:DATA_BITS] w_araddr;
  logic [DATA_WIDTH-1:0]         w_wdata;
  logic [DATA_WIDTH-1:0]         w_rdata;
  logic [ID_WIDTH-1:0]           w_arid;
  logic [RD_CNT_W-1:0]           r_rd_cnt;

  alrdwr_rr_sel u_w_sel (
    .clk           (clk),
    .rst           (rst),
    .i_req         ({s1_al.wvalid, s0_al.wvalid}),
    .i_gate        (1'b1),
    .i_ready       (m_al.wready),
    .o_sel         (w_w_sel),
    .o_valid       (m_al.wvalid),
    .o_grant_ready (w_wready)
  );

  alrdwr_rr_sel u_ar_sel (
    .clk           (clk),
    .rst           (rst),
    .i_req         ({s1_al.arvalid, s0_al.arvalid}),
    .i_gate        (w_ar_gate),
    .i_ready       (m_al.arready),
    .o_sel         (w_ar_sel),
    .o_valid       (m_al.arvalid),
    .o_grant_ready (w_arready)
  );

  assign w_waddr  = (w_w_sel == AL_PORT1) ? s1_al.waddr : s0_al.waddr;
  assign w_wdata  = (w_w_sel == AL_PORT1) ? s1_al.wdata : s0_al.wdata;
  assign w_araddr = (w_ar_sel == AL_PORT1) ? s1_al.araddr : s0_al.araddr;
  assign w_arid   = (w_ar_sel == AL_PORT1) ? s1_al.arid : s0_al.arid;

  assign m_al.waddr  = w_waddr;
  assign m_al.wdata  = w_wdata;
  assign m_al.araddr = w_araddr;
  assign m_al.arid   = MID_W'(al_widen_id(w_ar_sel, 32'(w_arid), ID_WIDTH));

  assign s0_al.wready  = w_wready[0];
  assign s1_al.wready  = w_wready[1];
  assign s0_al.arready = w_arready[0];
  assign s1_al.arready = w_arready[1];

  // Response routing keys off the port bit the AR mux placed above the upstream ID.
  assign w_rport       = m_al.rid[ID_WIDTH];
  assign w_rdata       = m_al.rdata;
  assign s0_al.rdata   = w_rdata;
  assign s1_al.rdata   = w_rdata;
  assign s0_al.rid     = m_al.rid[ID_WIDTH-1:0];
  assign s1_al.rid     = m_al.rid[ID_WIDTH-1:0];
  assign s0_al.rvalid  = m_al.rvalid & ~w_rport;
  assign s1_al.rvalid  = m_al.rvalid & w_rport;
  assign m_al.rready   = w_rport ? s1_al.rready : s0_al.rready;

  assign w_ar_gate = (r_rd_cnt != MAX_RD_C);
  assign w_ar_hs   = m_al.arvalid & m_al.arready;
  assign w_r_hs    = m_al.rvalid & m_al.rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
    end else begin
      case ({w_ar_hs, w_r_hs})
        2'b10:   r_rd_cnt <= r_rd_cnt + RD_CNT_W'(1);
        2'b01:   if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - RD_CNT_W'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  a_no_r_underflow: assert property (@(posedge clk) disable iff (rst)
    !(w_r_hs && (r_rd_cnt == '0)));

endmodule

// File: tb/tb_alrdwr_arb2.sv
// Directed self-checking bench for the two-master AL arbiter.
module tb_alrdwr_arb2;

  localparam int unsigned AW = 12;
  localparam int unsigned DB = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned MR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alrdwr_arb2_if #(.ADDR_WIDTH(AW), .DATA_BITS(DB), .ID_WIDTH(IW))     s0_if ();
  alrdwr_arb2_if #(.ADDR_WIDTH(AW), .DATA_BITS(DB), .ID_WIDTH(IW))     s1_if ();
  alrdwr_arb2_if #(.ADDR_WIDTH(AW), .DATA_BITS(DB), .ID_WIDTH(IW + 1)) m_if ();

  alrdwr_arb2 #(
    .ADDR_WIDTH (AW),
    .DATA_BITS  (DB),
    .ID_WIDTH   (IW),
    .MAX_RD     (MR)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s0_al (s0_if),
    .s1_al (s1_if),
    .m_al  (m_if)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_if.waddr = '0; s0_if.wdata = '0; s0_if.wvalid = 1'b0;
    s0_if.araddr = '0; s0_if.arid = '0; s0_if.arvalid = 1'b0; s0_if.rready = 1'b0;
    s1_if.waddr = '0; s1_if.wdata = '0; s1_if.wvalid = 1'b0;
    s1_if.araddr = '0; s1_if.arid = '0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b0;
    m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.rdata = '0; m_if.rid = '0; m_if.rvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_addr;

    // Reset state with idle inputs
    do_reset();
    #1;
    check("rst_m_wvalid",  64'(m_if.wvalid),    64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid),   64'd0);
    check("rst_s0_wready", 64'(s0_if.wready),   64'd0);
    check("rst_s1_wready", 64'(s1_if.wready),   64'd0);
    check("rst_s0_arrdy",  64'(s0_if.arready),  64'd0);
    check("rst_s1_arrdy",  64'(s1_if.arready),  64'd0);
    check("rst_s0_rvalid", 64'(s0_if.rvalid),   64'd0);
    check("rst_s1_rvalid", 64'(s1_if.rvalid),   64'd0);
    check("rst_m_rready",  64'(m_if.rready),    64'd0);
    check("rst_rd_cnt",    64'(dut.r_rd_cnt),   64'd0);

    // Single-port write
    do_reset();
    s0_if.waddr = 10'h010; s0_if.wdata = 32'hDEADBEEF; s0_if.wvalid = 1'b1;
    m_if.wready = 1'b1;
    #1;
    check("t1_waddr",     64'(m_if.waddr),    64'h10);
    check("t1_wdata",     64'(m_if.wdata),    64'hDEADBEEF);
    check("t1_wvalid",    64'(m_if.wvalid),   64'd1);
    check("t1_s0_wready", 64'(s0_if.wready),  64'd1);
    check("t1_s1_wready", 64'(s1_if.wready),  64'd0);
    step();

    // Simultaneous writes alternate starting with port 0
    do_reset();
    s0_if.waddr = 10'h100; s0_if.wvalid = 1'b1;
    s1_if.waddr = 10'h200; s1_if.wvalid = 1'b1;
    m_if.wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_addr = (i % 2 == 0) ? 64'h100 : 64'h200;
      check("t2_waddr",     64'(m_if.waddr),   exp_addr);
      check("t2_s0_wready", 64'(s0_if.wready), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("t2_s1_wready", 64'(s1_if.wready), (i % 2 == 0) ? 64'd0 : 64'd1);
      step();
    end

    // Lock: s0 stalled, s1 arrives later; last grant was s0 so a tie would favour s1
    do_reset();
    s0_if.waddr = 10'h011; s0_if.wvalid = 1'b1; m_if.wready = 1'b1;
    step();
    s0_if.waddr = 10'h030; m_if.wready = 1'b0;
    #1;
    check("t3_c0_waddr", 64'(m_if.waddr), 64'h30);
    check("t3_c0_s0rdy", 64'(s0_if.wready), 64'd0);
    step();
    s1_if.waddr = 10'h040; s1_if.wvalid = 1'b1;
    #1;
    check("t3_c1_waddr", 64'(m_if.waddr), 64'h30);
    step();
    #1;
    check("t3_c2_waddr", 64'(m_if.waddr), 64'h30);
    check("t3_c2_lock",  64'(dut.u_w_sel.r_lock), 64'd1);
    step();
    m_if.wready = 1'b1;
    #1;
    check("t3_hs_waddr", 64'(m_if.waddr),    64'h30);
    check("t3_hs_s0rdy", 64'(s0_if.wready),  64'd1);
    check("t3_hs_s1rdy", 64'(s1_if.wready),  64'd0);
    step();
    s0_if.wvalid = 1'b0;
    #1;
    check("t3_s1_waddr", 64'(m_if.waddr),   64'h40);
    check("t3_s1_rdy",   64'(s1_if.wready), 64'd1);
    step();

    // Read routing via ID MSB
    do_reset();
    s1_if.araddr = 10'h020; s1_if.arid = 1'b1; s1_if.arvalid = 1'b1;
    m_if.arready = 1'b1;
    #1;
    check("t4_arid",    64'(m_if.arid),     64'h3);
    check("t4_araddr",  64'(m_if.araddr),   64'h20);
    check("t4_arvalid", 64'(m_if.arvalid),  64'd1);
    check("t4_s1_ardy", 64'(s1_if.arready), 64'd1);
    check("t4_s0_ardy", 64'(s0_if.arready), 64'd0);
    step();
    idle();
    check("t4_cnt1", 64'(dut.r_rd_cnt), 64'd1);
    m_if.rvalid = 1'b1; m_if.rid = 2'b11; m_if.rdata = 32'h55; s1_if.rready = 1'b1;
    #1;
    check("t4_s1_rvalid", 64'(s1_if.rvalid), 64'd1);
    check("t4_s0_rvalid", 64'(s0_if.rvalid), 64'd0);
    check("t4_s1_rid",    64'(s1_if.rid),    64'd1);
    check("t4_s1_rdata",  64'(s1_if.rdata),  64'h55);
    check("t4_m_rready",  64'(m_if.rready),  64'd1);
    step();
    idle();
    check("t4_cnt0", 64'(dut.r_rd_cnt), 64'd0);

    // Outstanding limit
    do_reset();
    s0_if.araddr = 10'h040; s0_if.arvalid = 1'b1; m_if.arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_s0_ardy", 64'(s0_if.arready), (i < 4) ? 64'd1 : 64'd0);
      check("t5_arvalid", 64'(m_if.arvalid),  (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    check("t5_cnt_full", 64'(dut.r_rd_cnt), 64'd4);
    m_if.rvalid = 1'b1; m_if.rid = 2'b00; s0_if.rready = 1'b1;
    #1;
    check("t5_s0_rvalid", 64'(s0_if.rvalid),  64'd1);
    check("t5_s1_rvalid", 64'(s1_if.rvalid),  64'd0);
    check("t5_ardy_full", 64'(s0_if.arready), 64'd0);
    step();
    m_if.rvalid = 1'b0; s0_if.rready = 1'b0;
    #1;
    check("t5_fifth_ardy", 64'(s0_if.arready), 64'd1);
    step();
    s0_if.arvalid = 1'b0;
    check("t5_cnt_refill", 64'(dut.r_rd_cnt), 64'd4);

    // Drain to 2, then simultaneous AR and R handshake
    m_if.rvalid = 1'b1; m_if.rid = 2'b00; s0_if.rready = 1'b1;
    step();
    step();
    m_if.rvalid = 1'b0; s0_if.rready = 1'b0;
    check("t6_cnt2", 64'(dut.r_rd_cnt), 64'd2);
    s1_if.araddr = 10'h050; s1_if.arvalid = 1'b1; m_if.arready = 1'b1;
    m_if.rvalid = 1'b1; m_if.rid = 2'b00; s0_if.rready = 1'b1;
    #1;
    check("t6_s1_ardy", 64'(s1_if.arready), 64'd1);
    check("t6_m_rrdy",  64'(m_if.rready),   64'd1);
    step();
    idle();
    check("t6_cnt_same", 64'(dut.r_rd_cnt), 64'd2);

    // Reset mid-stall: s1 locked, then reset, then tie must go to port 0
    s1_if.waddr = 10'h060; s1_if.wvalid = 1'b1;
    step();
    s0_if.waddr = 10'h070; s0_if.wvalid = 1'b1;
    #1;
    check("t6_lock_addr", 64'(m_if.waddr), 64'h60);
    check("t6_lock_set",  64'(dut.u_w_sel.r_lock), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_rst_cnt",   64'(dut.r_rd_cnt), 64'd0);
    check("t6_rst_lock",  64'(dut.u_w_sel.r_lock), 64'd0);
    check("t6_rst_tie",   64'(m_if.waddr), 64'h70);
    m_if.wready = 1'b1;
    #1;
    check("t6_rst_s0rdy", 64'(s0_if.wready), 64'd1);
    check("t6_rst_s1rdy", 64'(s1_if.wready), 64'd0);
    step();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
